// File: rtl/systolic_link_io_pkg.sv
// Shared definitions for the systolic array host-side link: slot phases,
// control-nibble codes and the word layout carried through the TX FIFO.
package systolic_link_io_pkg;

    // Slot phase 0 carries the most significant nibble, phase 3 the least.
    localparam logic [1:0] PH_MSB = 2'd0;
    localparam logic [1:0] PH_LSB = 2'd3;

    // Control-nibble address codes understood by the array cells.
    localparam logic [3:0] CTRL_PASS   = 4'b0000;
    localparam logic [3:0] CTRL_C_LOW  = 4'b1000;
    localparam logic [3:0] CTRL_C_HIGH = 4'b1001;

    localparam int WORD_W = 40;

    typedef struct packed {
        logic [15:0] col;
        logic [15:0] row;
        logic [3:0]  col_ctrl;
        logic [3:0]  row_ctrl;
    } tx_word_t;

    // Idle slot: zero data, both cells told to pass through.
    localparam tx_word_t TX_IDLE = '{col: 16'h0000, row: 16'h0000,
                                     col_ctrl: CTRL_PASS, row_ctrl: CTRL_PASS};

    // A/B operand load codes: 01xx or 0x1x.
    function automatic logic is_ctrl_ab(input logic [3:0] c);
        return (c[3:2] == 2'b01) || (!c[3] && c[1]);
    endfunction

endpackage

// File: rtl/systolic_link_fifo.sv
// Small synchronous FIFO (1..4 entries) holding whole TX words until their slot.
module systolic_link_fifo
    import systolic_link_io_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    // Storage is sized for the largest allowed depth so the 2-bit pointers
    // index it without width adaptation; only DEPTH entries are ever used.
    logic [WORD_W-1:0] mem_q [4];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q;
    logic              do_push, do_pop;

    // A full FIFO refuses a push even if a pop happens on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign full_o  = (count_q == 3'(DEPTH));
    assign empty_o = (count_q == 3'd0);
    assign rdata_o = mem_q[rd_ptr_q];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Data array write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + 3'(do_push) - 3'(do_pop);
        end
    end

endmodule

// File: rtl/systolic_link_io.sv
// Host-side edge adapter for the systolic array: buffers TX words and
// serialises them MSB nibble first in 4-cycle slots, and rebuilds RX words
// from the nibble stream leaving the far edge of the array.
module systolic_link_io
    import systolic_link_io_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_col,
    input  logic [15:0] s_row,
    input  logic [3:0]  s_col_ctrl,
    input  logic [3:0]  s_row_ctrl,
    output logic [3:0]  col_nib,
    output logic [3:0]  row_nib,
    output logic        col_ctrl_bit,
    output logic        row_ctrl_bit,
    output logic [1:0]  phase,
    input  logic [3:0]  rx_col_nib,
    input  logic [3:0]  rx_row_nib,
    input  logic        rx_col_ctrl,
    input  logic        rx_row_ctrl,
    output logic        m_valid,
    output logic [15:0] m_col,
    output logic [15:0] m_row,
    output logic [3:0]  m_col_ctrl,
    output logic [3:0]  m_row_ctrl,
    output logic        tx_underflow
);

    logic [1:0]  phase_q, phase_d;
    tx_word_t    cur_q, cur_d;
    tx_word_t    fifo_head;
    logic        fifo_full, fifo_empty, slot_end, pop;
    logic        underflow_q, underflow_d;
    logic [11:0] rx_col_q, rx_col_d, rx_row_q, rx_row_d;
    logic [2:0]  rx_cc_q, rx_cc_d, rx_rc_q, rx_rc_d;
    logic        m_valid_q, m_valid_d;
    tx_word_t    m_word_q, m_word_d;
    logic [1:0]  nib_sel;

    assign slot_end = (phase_q == PH_LSB);
    assign pop      = slot_end && !fifo_empty;

    systolic_link_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s_valid),
        .pop_i   (pop),
        .wdata_i ({s_col, s_row, s_col_ctrl, s_row_ctrl}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // s_ready is forced low during reset even though the FIFO reads empty.
    assign s_ready      = rst_n && !fifo_full;
    assign phase        = phase_q;
    assign tx_underflow = underflow_q;
    assign m_valid      = m_valid_q;
    assign m_col        = m_word_q.col;
    assign m_row        = m_word_q.row;
    assign m_col_ctrl   = m_word_q.col_ctrl;
    assign m_row_ctrl   = m_word_q.row_ctrl;

    // TX drive: phase p selects nibble/bit (3-p), so phase 0 carries the MSBs.
    always_comb begin
        nib_sel      = 2'd3 - phase_q;
        col_nib      = cur_q.col[{nib_sel, 2'b00} +: 4];
        row_nib      = cur_q.row[{nib_sel, 2'b00} +: 4];
        col_ctrl_bit = cur_q.col_ctrl[nib_sel];
        row_ctrl_bit = cur_q.row_ctrl[nib_sel];
    end

    // Next state: phase count, slot load at the 3->0 edge, RX shift/commit.
    always_comb begin
        phase_d     = phase_q + 2'd1;
        cur_d       = cur_q;
        underflow_d = underflow_q;
        rx_col_d    = rx_col_q;
        rx_row_d    = rx_row_q;
        rx_cc_d     = rx_cc_q;
        rx_rc_d     = rx_rc_q;
        m_valid_d   = slot_end;
        m_word_d    = m_word_q;
        if (slot_end) begin
            if (!fifo_empty) begin
                cur_d = fifo_head;
            end else begin
                cur_d       = TX_IDLE;
                underflow_d = 1'b1;
            end
            m_word_d.col      = {rx_col_q, rx_col_nib};
            m_word_d.row      = {rx_row_q, rx_row_nib};
            m_word_d.col_ctrl = {rx_cc_q, rx_col_ctrl};
            m_word_d.row_ctrl = {rx_rc_q, rx_row_ctrl};
        end else begin
            rx_col_d = {rx_col_q[7:0], rx_col_nib};
            rx_row_d = {rx_row_q[7:0], rx_row_nib};
            rx_cc_d  = {rx_cc_q[1:0], rx_col_ctrl};
            rx_rc_d  = {rx_rc_q[1:0], rx_row_ctrl};
        end
    end

    // State registers; reset discards any in-flight slot and partial RX word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PH_MSB;
            cur_q       <= TX_IDLE;
            underflow_q <= 1'b0;
            rx_col_q    <= '0;
            rx_row_q    <= '0;
            rx_cc_q     <= '0;
            rx_rc_q     <= '0;
            m_valid_q   <= 1'b0;
            m_word_q    <= '0;
        end else begin
            phase_q     <= phase_d;
            cur_q       <= cur_d;
            underflow_q <= underflow_d;
            rx_col_q    <= rx_col_d;
            rx_row_q    <= rx_row_d;
            rx_cc_q     <= rx_cc_d;
            rx_rc_q     <= rx_rc_d;
            m_valid_q   <= m_valid_d;
            m_word_q    <= m_word_d;
        end
    end

endmodule

// File: tb/tb_systolic_link_io.sv
// Randomised scoreboard bench for systolic_link_io with TX looped back to RX.
module tb_systolic_link_io;
    import systolic_link_io_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_col = '0, s_row = '0;
    logic [3:0]  s_col_ctrl = '0, s_row_ctrl = '0;
    logic [3:0]  col_nib, row_nib;
    logic        col_ctrl_bit, row_ctrl_bit;
    logic [1:0]  phase;
    logic [3:0]  rx_col_nib, rx_row_nib;
    logic        rx_col_ctrl, rx_row_ctrl;
    logic        m_valid;
    logic [15:0] m_col, m_row;
    logic [3:0]  m_col_ctrl, m_row_ctrl;
    logic        tx_underflow;

    always #5 clk = ~clk;

    systolic_link_io #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_col(s_col), .s_row(s_row), .s_col_ctrl(s_col_ctrl), .s_row_ctrl(s_row_ctrl),
        .col_nib(col_nib), .row_nib(row_nib),
        .col_ctrl_bit(col_ctrl_bit), .row_ctrl_bit(row_ctrl_bit),
        .phase(phase),
        .rx_col_nib(rx_col_nib), .rx_row_nib(rx_row_nib),
        .rx_col_ctrl(rx_col_ctrl), .rx_row_ctrl(rx_row_ctrl),
        .m_valid(m_valid), .m_col(m_col), .m_row(m_row),
        .m_col_ctrl(m_col_ctrl), .m_row_ctrl(m_row_ctrl),
        .tx_underflow(tx_underflow)
    );

    // Loopback: the array edge is replaced by a wire.
    assign rx_col_nib  = col_nib;
    assign rx_row_nib  = row_nib;
    assign rx_col_ctrl = col_ctrl_bit;
    assign rx_row_ctrl = row_ctrl_bit;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: word queue of depth DEPTH, slot index by cycle count.
    tx_word_t mq[$];
    tx_word_t exp_tx[$];
    tx_word_t exp_rx[$];
    logic [1:0] m_ph = 2'd0;
    logic m_uf = 1'b0;
    logic m_primed = 1'b0;

    initial begin
        tx_word_t w;
        bit acc;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                exp_tx.delete();
                exp_rx.delete();
                exp_tx.push_back(TX_IDLE);
                exp_rx.push_back(TX_IDLE);
                m_ph = 2'd0;
                m_uf = 1'b0;
                m_primed = 1'b0;
            end else begin
                acc = s_valid && (mq.size() < DEPTH);
                if (m_ph == 2'd3) begin
                    if (mq.size() > 0) begin
                        w = mq.pop_front();
                    end else begin
                        w = TX_IDLE;
                        m_uf = 1'b1;
                    end
                    exp_tx.push_back(w);
                    exp_rx.push_back(w);
                    m_primed = 1'b1;
                end
                if (acc) mq.push_back({s_col, s_row, s_col_ctrl, s_row_ctrl});
                m_ph = m_ph + 2'd1;
            end
        end
    end

    // Monitor: samples on the falling edge, rebuilds TX slots, pops scoreboards.
    initial begin
        logic [15:0] col_acc, row_acc;
        logic [3:0]  cc_acc, rc_acc;
        tx_word_t    w;
        col_acc = '0; row_acc = '0; cc_acc = '0; rc_acc = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("phase", 64'(phase), 64'(m_ph));
                chk("s_ready", 64'(s_ready), 64'(mq.size() < DEPTH));
                chk("tx_underflow", 64'(tx_underflow), 64'(m_uf));
                chk("m_valid", 64'(m_valid), 64'((m_ph == 2'd0) && m_primed));
                col_acc = {col_acc[11:0], col_nib};
                row_acc = {row_acc[11:0], row_nib};
                cc_acc  = {cc_acc[2:0], col_ctrl_bit};
                rc_acc  = {rc_acc[2:0], row_ctrl_bit};
                if (m_ph == 2'd3) begin
                    if (exp_tx.size() == 0) begin
                        chk("tx_slot_expected", 64'(exp_tx.size()), 64'd1);
                    end else begin
                        w = exp_tx.pop_front();
                        chk("tx_slot", {24'h0, col_acc, row_acc, cc_acc, rc_acc}, 64'(w));
                    end
                end
                if (m_valid) begin
                    if (exp_rx.size() == 0) begin
                        chk("rx_word_expected", 64'(exp_rx.size()), 64'd1);
                    end else begin
                        w = exp_rx.pop_front();
                        chk("rx_word", {24'h0, m_col, m_row, m_col_ctrl, m_row_ctrl}, 64'(w));
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string nm);
        chk(nm, {col_nib, row_nib, col_ctrl_bit, row_ctrl_bit, phase, s_ready, m_valid,
                 m_col, m_row, m_col_ctrl, m_row_ctrl, tx_underflow}, 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Call at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input tx_word_t w);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        {s_col, s_row, s_col_ctrl, s_row_ctrl} = w;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout actual=s_ready_low required=accept within 50 cycles");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_phase(input logic [1:0] p);
        int guard;
        guard = 0;
        while (m_ph != p && guard < 8) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic tx_word_t rand_word();
        tx_word_t w;
        w.col      = 16'($urandom);
        w.row      = 16'($urandom);
        w.col_ctrl = 4'($urandom);
        w.row_ctrl = 4'($urandom);
        return w;
    endfunction

    initial begin
        #1 check_reset_outputs("initial_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Empty FIFO: idle slots and sticky underflow.
        idle_cycles(12);

        // Single word pushed during phase 1.
        wait_phase(2'd1);
        send('{col: 16'hABCD, row: 16'h1234, col_ctrl: 4'b1000, row_ctrl: 4'b0100});
        idle_cycles(12);

        // Loopback pattern.
        wait_phase(2'd2);
        send('{col: 16'h0F0F, row: 16'hF0F0, col_ctrl: 4'b0011, row_ctrl: 4'b1100});
        idle_cycles(12);

        // Push/pop collision: one word queued, second pushed on the load edge.
        wait_phase(2'd0);
        send(rand_word());
        wait_phase(2'd3);
        send(rand_word());
        idle_cycles(16);

        // Backpressure from a fresh reset so underflow starts clear.
        apply_reset();
        for (int i = 0; i < 5; i++) send(rand_word());
        idle_cycles(30);

        // Reset in the middle of a transmitted word.
        wait_phase(2'd0);
        send(rand_word());
        wait_phase(2'd3);
        @(negedge clk);
        wait_phase(2'd2);
        apply_reset();
        idle_cycles(10);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) idle_cycles($urandom_range(1, 9));
            else send(rand_word());
        end
        idle_cycles(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
